alu_seq16: RTL and testbench

ALU_SEQ16 -- requirements
Module: alu_seq16

---
 rtl/alu_seq16_pkg.sv | 35 +++
 rtl/alu_seq16.sv | 146 ++++++++++++++
 tb/tb_alu_seq16.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq16_pkg.sv
// Shared types and ALU control constants for the 16-bit add/sub/compare
// sequencer that drives an external 8-bit ALU.
package alu_seq16_pkg;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'b00,
        OP_SUB16 = 2'b01,
        OP_CMP16 = 2'b10,
        OP_RSVD  = 2'b11
    } req_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [3:0] ALU_OP_NOP = 4'b0000;
    localparam logic [3:0] ALU_OP_ADD = 4'b0010;
    localparam logic [3:0] ALU_OP_SUB = 4'b0011;

    localparam logic ALU_OPTYPE_ARITH = 1'b0;
    localparam logic ALU_OPTYPE_IDLE  = 1'b1;

    // Two's-complement overflow from operand and result sign bits.
    function automatic logic calc_ovf(input logic is_sub, input logic a15,
                                      input logic b15, input logic r15);
        if (is_sub)
            return (a15 != b15) && (r15 != a15);
        return (a15 == b15) && (r15 != a15);
    endfunction

endpackage

// File: rtl/alu_seq16.sv
// Sequences a 16-bit ADD/SUB/CMP through an external 8-bit ALU: low byte,
// high byte, then an optional +/-1 fix-up pass when the low byte carried.
module alu_seq16
    import alu_seq16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_z,
    output logic        rsp_c,
    output logic        rsp_n,
    output logic        rsp_v,
    output logic        rsp_err,
    output logic        alu_optype,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_acc,
    output logic [7:0]  alu_reg,
    input  logic [7:0]  alu_out,
    input  logic        alu_c
);

    state_e      state, state_d;
    req_op_e     op_q;
    req_op_e     new_op;
    logic [15:0] a_q, b_q;
    logic [7:0]  lo_q, hi_q;
    logic        c1_q, c2_q;
    logic        is_sub;
    logic        finish;
    logic        carry_fin;
    logic [15:0] sum16;

    assign new_op    = req_op_e'(req_op);
    assign is_sub    = (op_q != OP_ADD16);
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_DONE);

    // The high byte is final either in HI (no low carry) or after FIX.
    assign finish    = ((state == ST_HI) && !c1_q) || (state == ST_FIX);
    assign sum16     = {alu_out, lo_q};
    assign carry_fin = (state == ST_FIX) ? (c2_q | alu_c) : alu_c;

    always_comb begin
        state_d    = state;
        alu_optype = ALU_OPTYPE_IDLE;
        alu_op     = ALU_OP_NOP;
        alu_acc    = 8'h00;
        alu_reg    = 8'h00;
        case (state)
            ST_IDLE: begin
                if (req_valid)
                    state_d = (new_op == OP_RSVD) ? ST_DONE : ST_LO;
            end
            ST_LO: begin
                alu_optype = ALU_OPTYPE_ARITH;
                alu_op     = is_sub ? ALU_OP_SUB : ALU_OP_ADD;
                alu_acc    = a_q[7:0];
                alu_reg    = b_q[7:0];
                state_d    = ST_HI;
            end
            ST_HI: begin
                alu_optype = ALU_OPTYPE_ARITH;
                alu_op     = is_sub ? ALU_OP_SUB : ALU_OP_ADD;
                alu_acc    = a_q[15:8];
                alu_reg    = b_q[15:8];
                state_d    = c1_q ? ST_FIX : ST_DONE;
            end
            ST_FIX: begin
                alu_optype = ALU_OPTYPE_ARITH;
                alu_op     = is_sub ? ALU_OP_SUB : ALU_OP_ADD;
                alu_acc    = hi_q;
                alu_reg    = 8'h01;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_ADD16;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            lo_q       <= 8'h00;
            hi_q       <= 8'h00;
            c1_q       <= 1'b0;
            c2_q       <= 1'b0;
            rsp_result <= 16'h0000;
            rsp_z      <= 1'b0;
            rsp_c      <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_v      <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_q  <= req_a;
                        b_q  <= req_b;
                        op_q <= new_op;
                        if (new_op == OP_RSVD) begin
                            rsp_result <= 16'h0000;
                            rsp_z      <= 1'b0;
                            rsp_c      <= 1'b0;
                            rsp_n      <= 1'b0;
                            rsp_v      <= 1'b0;
                            rsp_err    <= 1'b1;
                        end
                    end
                end
                ST_LO: begin
                    lo_q <= alu_out;
                    c1_q <= alu_c;
                end
                ST_HI: begin
                    hi_q <= alu_out;
                    c2_q <= alu_c;
                end
                default: ;
            endcase
            // Flags always reflect the true difference, even for CMP16.
            if (finish) begin
                rsp_result <= (op_q == OP_CMP16) ? 16'h0000 : sum16;
                rsp_z      <= (sum16 == 16'h0000);
                rsp_c      <= carry_fin;
                rsp_n      <= sum16[15];
                rsp_v      <= calc_ovf(is_sub, a_q[15], b_q[15], sum16[15]);
                rsp_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// Randomized and directed bench for alu_seq16 with an 8-bit ALU model
// and a 16-bit arithmetic reference.
module tb_alu_seq16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_z, rsp_c, rsp_n, rsp_v, rsp_err;
    logic        alu_optype;
    logic [3:0]  alu_op;
    logic [7:0]  alu_acc, alu_reg, alu_out;
    logic        alu_c;

    typedef struct packed {
        logic [15:0] res;
        logic        z, c, n, v, err;
        logic [7:0]  lat;
    } rsp_t;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    alu_seq16 dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_n(rsp_n), .rsp_v(rsp_v), .rsp_err(rsp_err),
        .alu_optype(alu_optype), .alu_op(alu_op), .alu_acc(alu_acc), .alu_reg(alu_reg),
        .alu_out(alu_out), .alu_c(alu_c)
    );

    // External 8-bit ALU: carry out for ADD, borrow for SUB.
    always_comb begin
        alu_out = 8'h00;
        alu_c   = 1'b0;
        if (alu_optype == 1'b0 && alu_op == 4'b0010) begin
            {alu_c, alu_out} = {1'b0, alu_acc} + {1'b0, alu_reg};
        end else if (alu_optype == 1'b0 && alu_op == 4'b0011) begin
            alu_out = alu_acc - alu_reg;
            alu_c   = (alu_acc < alu_reg);
        end
    end

    function automatic rsp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        rsp_t m;
        logic [16:0] full;
        logic [15:0] r;
        logic lowc;
        m = '0;
        if (op == 2'b11) begin
            m.err = 1'b1;
            m.lat = 8'd1;
            return m;
        end
        if (op == 2'b00) begin
            full = {1'b0, a} + {1'b0, b};
            r    = full[15:0];
            m.c  = full[16];
            m.v  = (a[15] == b[15]) && (r[15] != a[15]);
            lowc = (({1'b0, a[7:0]} + {1'b0, b[7:0]}) > 9'd255);
        end else begin
            r    = a - b;
            m.c  = (a < b);
            m.v  = (a[15] != b[15]) && (r[15] != a[15]);
            lowc = (a[7:0] < b[7:0]);
        end
        m.z   = (r == 16'h0000);
        m.n   = r[15];
        m.res = (op == 2'b10) ? 16'h0000 : r;
        m.lat = lowc ? 8'd4 : 8'd3;
        return m;
    endfunction

    // Issues one request, scrambles inputs after acceptance, waits for rsp_valid.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          output rsp_t got);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 2'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
        got.lat = 8'd1;
        while (!rsp_valid && got.lat < 8'd20) begin @(posedge clk); #1; got.lat++; end
        got.res = rsp_result; got.z = rsp_z; got.c = rsp_c;
        got.n = rsp_n; got.v = rsp_v; got.err = rsp_err;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 6))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return 16'h00FF;
            5: return 16'h0100;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        logic [40:0] got, exp;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = {req_ready, rsp_valid, rsp_result, rsp_z, rsp_c, rsp_n, rsp_v, rsp_err,
               alu_optype, alu_op, alu_acc, alu_reg};
        exp = {1'b1, 1'b0, 16'h0000, 5'b00000, 1'b1, 4'h0, 8'h00, 8'h00};
        total++;
        if (got !== exp) $display("FAIL reset_state got=%h exp=%h", got, exp);
        else pass_cnt++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
        logic [15:0] as  [7] = '{16'h00FF, 16'hFFFF, 16'h7F00, 16'h0100, 16'h0000, 16'h1234, 16'hFFFF};
        logic [15:0] bs  [7] = '{16'h0001, 16'h0001, 16'h0100, 16'h0001, 16'h0001, 16'h1234, 16'h0001};
        rsp_t exps [7];
        rsp_t got;
        //            res        z     c     n     v     err   lat
        exps[0] = '{16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
        exps[1] = '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4};
        exps[2] = '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3};
        exps[3] = '{16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
        exps[4] = '{16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4};
        exps[5] = '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
        exps[6] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], as[i], bs[i], got);
            total++;
            if (got !== exps[i]) $display("FAIL directed_%0d got=%h exp=%h", i, got, exps[i]);
            else pass_cnt++;
            release_rsp();
        end
    endtask

    task automatic test_alu_drive();
        logic [12:0] got, exp;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_a = 16'h5678; req_b = 16'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = {alu_optype, alu_op, alu_acc}; exp = {1'b0, 4'b0011, 8'h78};
        total++;
        if (got !== exp || alu_reg !== 8'h34) $display("FAIL alu_lo got=%h/%h exp=%h/34", got, alu_reg, exp);
        else pass_cnt++;
        @(posedge clk); #1;
        got = {alu_optype, alu_op, alu_acc}; exp = {1'b0, 4'b0011, 8'h56};
        total++;
        if (got !== exp || alu_reg !== 8'h12) $display("FAIL alu_hi got=%h/%h exp=%h/12", got, alu_reg, exp);
        else pass_cnt++;
        @(posedge clk); #1;
        got = {alu_optype, alu_op, alu_acc}; exp = {1'b1, 4'h0, 8'h00};
        total++;
        if (got !== exp || alu_reg !== 8'h00 || rsp_result !== 16'h4444)
            $display("FAIL alu_done got=%h/%h res=%h exp=%h/00 res=4444", got, alu_reg, rsp_result, exp);
        else pass_cnt++;
        release_rsp();
    endtask

    task automatic test_backpressure();
        rsp_t got, snap;
        run_op(2'b00, 16'h00FF, 16'h0001, got);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_op = 2'b01; req_a = 16'hAAAA; req_b = 16'h5555;
            @(posedge clk); #1;
            snap = got;
            snap.res = rsp_result; snap.z = rsp_z; snap.c = rsp_c;
            snap.n = rsp_n; snap.v = rsp_v; snap.err = rsp_err;
            total++;
            if (snap !== got || rsp_valid !== 1'b1 || req_ready !== 1'b0)
                $display("FAIL hold_%0d got=%h v=%b r=%b exp=%h v=1 r=0", i, snap, rsp_valid, req_ready, got);
            else pass_cnt++;
        end
        req_valid = 1'b0;
        release_rsp();
    endtask

    task automatic test_reset_mid_op();
        rsp_t got, exp;
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b00; req_a = 16'h00FF; req_b = 16'h0001;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL rst_async ready=%b valid=%b exp ready=1 valid=0", req_ready, rsp_valid);
        else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", req_ready);
        else pass_cnt++;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL rst_no_rsp got=%0d exp=0", seen);
        else pass_cnt++;
        run_op(2'b00, 16'h0001, 16'h0001, got);
        exp = '{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
        total++;
        if (got !== exp) $display("FAIL rst_next_op got=%h exp=%h", got, exp);
        else pass_cnt++;
        release_rsp();
    endtask

    task automatic test_random();
        rsp_t got, exp;
        logic [1:0]  op;
        logic [15:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = (i % 10 == 9) ? 2'b11 : 2'($urandom_range(0, 2));
            a = pick_val();
            b = pick_val();
            exp = model(op, a, b);
            run_op(op, a, b, got);
            total++;
            if (got !== exp) $display("FAIL random_%0d op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, got, exp);
            else pass_cnt++;
            release_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_alu_drive();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
